mtimer_clint: RTL and testbench
===============================

// Module: mtimer_clint
//
// PURPOSE
// - Core-local timer/software-interrupt source for one hart, feeding the privileged unit:
//   drives MTIME_CLINT, MTimerInt and MSwInt.
// - Holds mtime (free-running 64-bit, prescaled), mtimecmp and msip.
// - All three are read/written through a single-outstanding request/response register port.
//
// PARAMETERS
// - XLEN         64              data width of register port (32 or 64)
// - TICK_DIV     1               clk cycles per mtime increment (>=1)
// - MTIMECMP_RST 64'hFFFF..FFFF  reset value of mtimecmp (no interrupt out of reset)
//
// PORTS
// - clk          in   1           core clock
// - reset_n      in   1           synchronous, active-low reset
// - ReqValid     in   1           request present
// - ReqReady     out  1           request accepted when ReqValid&ReqReady
// - ReqWrite     in   1           1=write, 0=read
// - ReqAdr       in   16          byte offset, XLEN/8-aligned
// - ReqWData     in   XLEN        write data
// - ReqByteEn    in   XLEN/8      byte enables for writes
// - RspValid     out  1           response valid, held until RspReady
// - RspReady     in   1           response consumed
// - RspData      out  XLEN        read data (0 for writes/errors)
// - RspErr       out  1           unmapped or misaligned address
// - MTIME_CLINT  out  64          current mtime
// - MTimerInt    out  1           registered (mtime >= mtimecmp)
// - MSwInt       out  1           msip[0]
//
// BEHAVIOUR
// - Reset (reset_n=0 at clk edge): mtime=0, prescaler=0, mtimecmp=MTIMECMP_RST, msip=0,
//   MTimerInt=0, RspValid=0, RspData=0, RspErr=0.
// - Map: 0x0000 msip (bit0 only, rest RAZ/WI); 0x4000 mtimecmp; 0xBFF8 mtime.
//   XLEN=32: +4 selects upper word.
// - Other offsets, or ReqAdr[log2(XLEN/8)-1:0]!=0 -> RspErr=1, RspData=0, no state change.
// - Handshake: ReqReady = !RspValid | RspReady.
//   - Accept at cycle N -> RspValid=1 at N+1.
//   - Read data is captured from pre-write register values at N.
//   - Writes update registers at edge N, byte-merged by ReqByteEn.
//   - Back-to-back accepts are allowed when RspReady=1.
// - Prescaler counts 0..TICK_DIV-1; tick on TICK_DIV-1, then wraps to 0. TICK_DIV=1 -> tick every cycle.
// - mtime += 1 on tick; 2^64-1 wraps to 0.
// - mtime write in same cycle as tick: written value wins, no increment that cycle, prescaler unaffected.
// - mtimecmp write: MTimerInt re-evaluates on the next edge, so it is 1 cycle after the compare is true.
//   - Writing mtimecmp > mtime clears MTimerInt one cycle later.
//   - Writing mtime=0 with mtimecmp=0 keeps it set.
// - MSwInt follows msip combinationally from its register (same edge as write).
// - Reset mid-transaction: pending response dropped, RspValid=0.
//
// STRUCTURE
// - Package clint_pkg: address constants CLINT_MSIP/MTIMECMP/MTIME, plus the typedef clint_req_t
//   {write, adr, wdata, byteen}.
// - Sub-module mtime_counter: prescaler, 64-bit counter, byte-merged write port.
// - Top: decode, response register, mtimecmp/msip regs, compare register.
//
// TESTING
// - Reset with TICK_DIV=1 -> MTIME_CLINT=0, MTimerInt=0, MSwInt=0;
//   10 cycles later MTIME_CLINT=10.
// - TICK_DIV=4, 12 cycles after reset -> mtime=3; prescaler wrap exact on cycles 4,8,12.
// - Write mtimecmp=20, mtime counting from 0 -> MTimerInt rises the cycle after mtime==20;
//   write mtimecmp=100 -> falls next cycle.
// - Write mtime=64'hFFFF_FFFF_FFFF_FFFE, TICK_DIV=1 -> 2 cycles later mtime=0;
//   write on tick cycle -> written value held, no skip.
// - Write 0x0000=1 -> MSwInt=1; read 0x0000 -> RspData=1.
//   Read 0x1234 -> RspErr=1, RspData=0, state unchanged.
// - Hold RspReady=0 after accept -> ReqReady=0, RspValid/RspData stable;
//   assert reset_n=0 -> RspValid=0 next edge.

Source files
------------

// File: rtl/clint_pkg.sv
`default_nettype none
// ============================================================================
// Module : clint_pkg
// Brief  : Shared CLINT register map, request bundle and byte-merge helper.
// Rev    : 1.0
// ============================================================================
package clint_pkg;

  localparam logic [15:0] CLINT_MSIP     = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP = 16'h4000;
  localparam logic [15:0] CLINT_MTIME    = 16'hBFF8;

  // Carried at full 64-bit width; narrower ports zero-extend into it.
  typedef struct packed {
    logic        write;
    logic [15:0] adr;
    logic [63:0] wdata;
    logic [7:0]  byteen;
  } clint_req_t;

  function automatic logic [63:0] byteMerge(input logic [63:0] oldVal,
                                            input logic [63:0] newVal,
                                            input logic [7:0]  mask);
    logic [63:0] res;
    for (int b = 0; b < 8; b++) begin
      res[8*b +: 8] = mask[b] ? newVal[8*b +: 8] : oldVal[8*b +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mtime_counter.sv
`default_nettype none
// ============================================================================
// Module : mtime_counter
// Brief  : Prescaled free-running 64-bit mtime with a byte-merged write port.
// Rev    : 1.0
// ============================================================================
module mtime_counter
  import clint_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wrEn,
  input  logic [63:0] wrData,
  input  logic [7:0]  wrMask,
  output logic [63:0] mtime
);

  localparam int                c_preW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_preW-1:0] c_preMax = c_preW'(TICK_DIV - 1);

  logic [c_preW-1:0] r_prescale;
  logic [63:0]       r_mtime;
  logic              w_tick;

  assign w_tick = (r_prescale == c_preMax);
  assign mtime  = r_mtime;

  // A software write takes priority over the tick; the prescaler keeps its own phase.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_prescale <= '0;
      r_mtime    <= '0;
    end else begin
      r_prescale <= w_tick ? '0 : r_prescale + 1'b1;
      if (wrEn) begin
        r_mtime <= byteMerge(r_mtime, wrData, wrMask);
      end else if (w_tick) begin
        r_mtime <= r_mtime + 64'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mtimer_clint.sv
`default_nettype none
// ============================================================================
// Module : mtimer_clint
// Brief  : Core-local timer / software interrupt source with a req/rsp register port.
// Rev    : 1.0
// ============================================================================
module mtimer_clint
  import clint_pkg::*;
#(
  parameter int          XLEN         = 64,
  parameter int          TICK_DIV     = 1,
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWrite,
  input  logic [15:0]       ReqAdr,
  input  logic [XLEN-1:0]   ReqWData,
  input  logic [XLEN/8-1:0] ReqByteEn,
  output logic              RspValid,
  input  logic              RspReady,
  output logic [XLEN-1:0]   RspData,
  output logic              RspErr,
  output logic [63:0]       MTIME_CLINT,
  output logic              MTimerInt,
  output logic              MSwInt
);

  localparam int c_alignW = $clog2(XLEN/8);

  clint_req_t        w_req;
  logic              w_hiWord;
  logic              w_selMsip;
  logic              w_selCmp;
  logic              w_selTime;
  logic              w_err;
  logic              w_accept;
  logic              w_doWrite;
  logic [15:0]       w_base;
  logic [63:0]       w_wData;
  logic [7:0]        w_wMask;
  logic [63:0]       w_rdReg;
  logic [63:0]       w_rdLane;
  logic [63:0]       w_mtime;

  logic [63:0]       r_mtimecmp;
  logic              r_msip;
  logic              r_timerInt;
  logic              r_rspValid;
  logic              r_rspErr;
  logic [XLEN-1:0]   r_rspData;

  assign w_req = '{write: ReqWrite, adr: ReqAdr, wdata: 64'(ReqWData), byteen: 8'(ReqByteEn)};

  // On a 32-bit port, bit 2 picks the upper half of the 64-bit registers.
  always_comb begin
    w_hiWord  = (XLEN == 32) && w_req.adr[2];
    w_base    = {w_req.adr[15:3], 3'b000};
    w_selMsip = 1'b0;
    w_selCmp  = 1'b0;
    w_selTime = 1'b0;
    if (w_req.adr[c_alignW-1:0] == '0) begin
      if (w_base == CLINT_MSIP && !w_hiWord) begin
        w_selMsip = 1'b1;
      end else if (w_base == CLINT_MTIMECMP) begin
        w_selCmp = 1'b1;
      end else if (w_base == CLINT_MTIME) begin
        w_selTime = 1'b1;
      end
    end
    w_err = !(w_selMsip || w_selCmp || w_selTime);

    w_wData = w_hiWord ? {w_req.wdata[31:0], 32'b0} : w_req.wdata;
    w_wMask = w_hiWord ? {w_req.byteen[3:0], 4'b0}  : w_req.byteen;

    w_rdReg = '0;
    if (w_selMsip) begin
      w_rdReg = {63'b0, r_msip};
    end else if (w_selCmp) begin
      w_rdReg = r_mtimecmp;
    end else if (w_selTime) begin
      w_rdReg = w_mtime;
    end
    w_rdLane = w_hiWord ? {32'b0, w_rdReg[63:32]} : w_rdReg;
  end

  assign ReqReady  = !r_rspValid || RspReady;
  assign w_accept  = ReqValid && ReqReady;
  assign w_doWrite = w_accept && w_req.write && !w_err;

  mtime_counter #(
    .TICK_DIV (TICK_DIV)
  ) u_mtime (
    .clk     (clk),
    .reset_n (reset_n),
    .wrEn    (w_doWrite && w_selTime),
    .wrData  (w_wData),
    .wrMask  (w_wMask),
    .mtime   (w_mtime)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_mtimecmp <= MTIMECMP_RST;
      r_msip     <= 1'b0;
      r_timerInt <= 1'b0;
      r_rspValid <= 1'b0;
      r_rspErr   <= 1'b0;
      r_rspData  <= '0;
    end else begin
      r_timerInt <= (w_mtime >= r_mtimecmp);
      if (w_doWrite && w_selCmp) begin
        r_mtimecmp <= byteMerge(r_mtimecmp, w_wData, w_wMask);
      end
      if (w_doWrite && w_selMsip && w_wMask[0]) begin
        r_msip <= w_wData[0];
      end
      if (w_accept) begin
        r_rspValid <= 1'b1;
        r_rspErr   <= w_err;
        r_rspData  <= (w_err || w_req.write) ? '0 : w_rdLane[XLEN-1:0];
      end else if (RspReady) begin
        r_rspValid <= 1'b0;
      end
    end
  end

  assign RspValid    = r_rspValid;
  assign RspData     = r_rspData;
  assign RspErr      = r_rspErr;
  assign MTIME_CLINT = w_mtime;
  assign MTimerInt   = r_timerInt;
  assign MSwInt      = r_msip;

endmodule
`default_nettype wire

// File: tb/tb_mtimer_clint.sv
`default_nettype none
// ============================================================================
// Module : tb_mtimer_clint
// Brief  : Two CLINT instances (64-bit/div1, 32-bit/div4) against a behavioural model.
// Rev    : 1.0
// ============================================================================
module tb_mtimer_clint;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rv[2], wr[2], rr[2];
  logic [15:0] adr[2];
  logic [63:0] wd[2];
  logic [7:0]  be[2];

  logic        rdy0, rspV0, rspE0, ti0, sw0;
  logic [63:0] rspD0, mt0;
  logic        rdy1, rspV1, rspE1, ti1, sw1;
  logic [31:0] rspD1;
  logic [63:0] mt1;

  int nChecks = 0;
  int nPass   = 0;
  bit chkOn   = 1'b0;

  // Model state, index 0 = 64-bit/div1 instance, 1 = 32-bit/div4 instance.
  logic [63:0] mTime[2], mCmp[2], mRd[2];
  bit          mSw[2], mTi[2], mRv[2], mErr[2];
  int          mEdges[2];

  always #5 clk = ~clk;

  mtimer_clint #(.XLEN(64), .TICK_DIV(1)) dut0 (
    .clk(clk), .reset_n(reset_n), .ReqValid(rv[0]), .ReqReady(rdy0), .ReqWrite(wr[0]),
    .ReqAdr(adr[0]), .ReqWData(wd[0]), .ReqByteEn(be[0]), .RspValid(rspV0), .RspReady(rr[0]),
    .RspData(rspD0), .RspErr(rspE0), .MTIME_CLINT(mt0), .MTimerInt(ti0), .MSwInt(sw0));

  mtimer_clint #(.XLEN(32), .TICK_DIV(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .ReqValid(rv[1]), .ReqReady(rdy1), .ReqWrite(wr[1]),
    .ReqAdr(adr[1]), .ReqWData(wd[1][31:0]), .ReqByteEn(be[1][3:0]), .RspValid(rspV1),
    .RspReady(rr[1]), .RspData(rspD1), .RspErr(rspE1), .MTIME_CLINT(mt1), .MTimerInt(ti1),
    .MSwInt(sw1));

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // One clock edge of the register file, from the architectural rules.
  task automatic modelStep(input int i, input int xlen, input int div);
    bit          acc, hi, nextTi;
    int          kind, lane;
    logic [63:0] reg64, rdv, nextTime;
    acc    = rv[i] && (!mRv[i] || rr[i]);
    nextTi = (mTime[i] >= mCmp[i]);
    mEdges[i]++;
    nextTime = ((mEdges[i] % div) == 0) ? mTime[i] + 64'd1 : mTime[i];
    if (acc) begin
      kind = 0;
      hi   = (xlen == 32) && adr[i][2];
      if (adr[i] == 16'h0000) kind = 1;
      else if (adr[i] == 16'h4000 || (xlen == 32 && adr[i] == 16'h4004)) kind = 2;
      else if (adr[i] == 16'hBFF8 || (xlen == 32 && adr[i] == 16'hBFFC)) kind = 3;
      reg64 = (kind == 1) ? {63'b0, mSw[i]} : (kind == 2) ? mCmp[i] : (kind == 3) ? mTime[i] : 64'd0;
      rdv   = (xlen == 64) ? reg64 : (hi ? (reg64 >> 32) : (reg64 & 64'hFFFF_FFFF));
      if (wr[i] && kind != 0) begin
        if (kind == 3) nextTime = mTime[i];
        for (int b = 0; b < xlen / 8; b++) begin
          if (be[i][b]) begin
            lane = hi ? b + 4 : b;
            if (kind == 1 && b == 0) mSw[i] = wd[i][0];
            if (kind == 2) mCmp[i][lane*8 +: 8] = wd[i][b*8 +: 8];
            if (kind == 3) nextTime[lane*8 +: 8] = wd[i][b*8 +: 8];
          end
        end
      end
      mRv[i]  = 1'b1;
      mErr[i] = (kind == 0);
      mRd[i]  = (kind == 0 || wr[i]) ? 64'd0 : rdv;
    end else if (rr[i]) begin
      mRv[i] = 1'b0;
    end
    mTi[i]   = nextTi;
    mTime[i] = nextTime;
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) begin
        mTime[i] = 64'd0; mCmp[i] = '1; mRd[i] = 64'd0; mSw[i] = 0;
        mTi[i] = 0; mRv[i] = 0; mErr[i] = 0; mEdges[i] = 0;
      end else begin
        modelStep(i, (i == 0) ? 64 : 32, (i == 0) ? 1 : 4);
      end
    end
  end

  always @(negedge clk) begin
    if (chkOn) begin
      check("ReqReady0", rdy0, !mRv[0] || rr[0]);
      check("RspValid0", rspV0, mRv[0]);
      check("RspData0", rspD0, mRd[0]);
      check("RspErr0", rspE0, mErr[0]);
      check("mtime0", mt0, mTime[0]);
      check("MTimerInt0", ti0, mTi[0]);
      check("MSwInt0", sw0, mSw[0]);
      check("ReqReady1", rdy1, !mRv[1] || rr[1]);
      check("RspValid1", rspV1, mRv[1]);
      check("RspData1", rspD1, mRd[1]);
      check("RspErr1", rspE1, mErr[1]);
      check("mtime1", mt1, mTime[1]);
      check("MTimerInt1", ti1, mTi[1]);
      check("MSwInt1", sw1, mSw[1]);
    end
  end

  task automatic reqTask(input int i, input logic w, input logic [15:0] a,
                         input logic [63:0] d, input logic [7:0] b);
    @(posedge clk); #2;
    rv[i] = 1'b1; wr[i] = w; adr[i] = a; wd[i] = d; be[i] = b;
    @(posedge clk); #2;
    rv[i] = 1'b0; wr[i] = 1'b0;
  endtask

  initial begin
    logic [15:0] adrTab [10];
    adrTab = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC,
               16'h1234, 16'h4001, 16'h0004, 16'h4008, 16'hBFFA};
    for (int i = 0; i < 2; i++) begin
      rv[i] = 0; wr[i] = 0; rr[i] = 1; adr[i] = '0; wd[i] = '0; be[i] = '0;
    end
    repeat (3) @(posedge clk);
    chkOn = 1'b1;
    @(negedge clk);
    check("rst mtime", mt0, 64'd0);
    check("rst MTimerInt", ti0, 64'd0);
    check("rst MSwInt", sw0, 64'd0);
    check("rst RspValid", rspV0, 64'd0);
    @(posedge clk); #2 reset_n = 1'b1;

    // Both timers from reset: div1 counts every edge, div4 every fourth.
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); @(negedge clk);
      check("div1 count", mt0, 64'(k));
      check("div4 count", mt1, 64'(k / 4));
    end

    reqTask(0, 1, 16'hBFF8, 64'd0, 8'hFF);
    reqTask(0, 1, 16'h4000, 64'd20, 8'hFF);
    repeat (18) @(posedge clk);
    @(negedge clk);
    check("cmp20 mtime", mt0, 64'd20);
    check("cmp20 before", ti0, 64'd0);
    @(posedge clk); @(negedge clk);
    check("cmp20 rise", ti0, 64'd1);
    reqTask(0, 1, 16'h4000, 64'd100, 8'hFF);
    @(negedge clk);
    check("cmp100 still", ti0, 64'd1);
    @(posedge clk); @(negedge clk);
    check("cmp100 fall", ti0, 64'd0);

    reqTask(0, 1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
    @(negedge clk);
    check("wr mtime held", mt0, 64'hFFFF_FFFF_FFFF_FFFE);
    @(posedge clk); @(negedge clk);
    check("mtime max", mt0, 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clk); @(negedge clk);
    check("mtime wrap", mt0, 64'd0);

    reqTask(0, 1, 16'h0000, 64'd1, 8'hFF);
    @(negedge clk);
    check("msip set", sw0, 64'd1);
    reqTask(0, 0, 16'h0000, 64'd0, 8'h00);
    @(negedge clk);
    check("rd msip data", rspD0, 64'd1);
    check("rd msip err", rspE0, 64'd0);
    reqTask(0, 0, 16'h1234, 64'd0, 8'h00);
    @(negedge clk);
    check("unmapped err", rspE0, 64'd1);
    check("unmapped data", rspD0, 64'd0);

    reqTask(1, 1, 16'h4004, 64'h1234_5678, 8'h0F);
    reqTask(1, 0, 16'h4004, 64'd0, 8'h00);
    @(negedge clk);
    check("x32 cmp hi", rspD1, 64'h1234_5678);
    reqTask(1, 0, 16'h4000, 64'd0, 8'h00);
    @(negedge clk);
    check("x32 cmp lo", rspD1, 64'hFFFF_FFFF);

    @(posedge clk); #2 rr[0] = 1'b0;
    reqTask(0, 0, 16'h0000, 64'd0, 8'h00);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hold ReqReady", rdy0, 64'd0);
      check("hold RspValid", rspV0, 64'd1);
      check("hold RspData", rspD0, 64'd1);
    end
    @(posedge clk); #2 reset_n = 1'b0;
    @(posedge clk); @(negedge clk);
    check("rst drops rsp", rspV0, 64'd0);
    @(posedge clk); #2 reset_n = 1'b1; rr[0] = 1'b1;

    repeat (3000) begin
      @(posedge clk); #2;
      reset_n = ($urandom_range(0, 499) != 0);
      for (int i = 0; i < 2; i++) begin
        rv[i]  = $urandom_range(0, 1);
        wr[i]  = $urandom_range(0, 1);
        adr[i] = adrTab[$urandom_range(0, 9)];
        wd[i]  = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 300));
        be[i]  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
        rr[i]  = ($urandom_range(0, 3) != 0);
      end
    end
    @(posedge clk); #2;
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rv[i] = 0; rr[i] = 1;
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    chkOn = 1'b0;
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
`default_nettype wire
